// File: rtl/bot_port_pkg.sv
// Shared definitions for the Rojobot/Nexys4 I/O port bus: arbiter states, master index
// and the KCPSM6 port address map used by the bot interface and both bus masters.
package bot_port_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StStrb,
        StRwait,
        StDone
    } arb_state_e;

    // Master index: m0 = debug UART host bridge, m1 = motion-script engine
    typedef logic mst_idx_t;

    localparam mst_idx_t MST_M0 = 1'b0;
    localparam mst_idx_t MST_M1 = 1'b1;

    // Output ports
    localparam logic [7:0] PA_LEDS      = 8'h02;
    localparam logic [7:0] PA_DIG3      = 8'h03;
    localparam logic [7:0] PA_DIG2      = 8'h04;
    localparam logic [7:0] PA_DIG1      = 8'h05;
    localparam logic [7:0] PA_DIG0      = 8'h06;
    localparam logic [7:0] PA_DP        = 8'h07;
    localparam logic [7:0] PA_MOTCTL_IN = 8'h09;

    // Input ports
    localparam logic [7:0] PA_BTNSW     = 8'h00;
    localparam logic [7:0] PA_SLSWTCH   = 8'h01;
    localparam logic [7:0] PA_LOCX      = 8'h0A;
    localparam logic [7:0] PA_LOCY      = 8'h0B;
    localparam logic [7:0] PA_BOTINFO   = 8'h0C;
    localparam logic [7:0] PA_SENSORS   = 8'h0D;
    localparam logic [7:0] PA_LMDIST    = 8'h0E;
    localparam logic [7:0] PA_RMDIST    = 8'h0F;

    // Read wait count loaded on entry to the read-wait state; out-of-range latencies clamp
    // into the supported 1..3 window.
    function automatic logic [1:0] rd_cnt_init(input int unsigned lat);
        if (lat < 1) begin
            return 2'd1;
        end else if (lat > 3) begin
            return 2'd3;
        end else begin
            return lat[1:0];
        end
    endfunction

endpackage

// File: rtl/bot_rr_pick.sv
// Two-way request picker: round-robin on ties, or strict m0 priority when
// BOT_ARB_FIXED_PRIO_EN is defined.
module bot_rr_pick
    import bot_port_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   last_gnt,
    output mst_idx_t   winner
);

`ifdef BOT_ARB_FIXED_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        winner = req[0] ? MST_M0 : MST_M1;
    end
`else
    always_comb begin
        winner = MST_M0;
        case (req)
            2'b01:   winner = MST_M0;
            2'b10:   winner = MST_M1;
            2'b11:   winner = ~last_gnt;
            default: winner = MST_M0;
        endcase
    end
`endif

endmodule

// File: rtl/bot_port_arbiter.sv
// Arbitrates two stallable masters onto the KCPSM6 bot port bus and sequences each grant
// into a timed port write or read. Tie policy selected by BOT_ARB_FIXED_PRIO_EN.
module bot_port_arbiter
    import bot_port_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_avail,
    output logic              bus_busy,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    output logic              write_strobe,
    output logic              read_strobe,
    input  logic [DATA_W-1:0] in_port
);

    localparam logic [1:0] RD_CNT_INIT = rd_cnt_init(RD_LAT);

    arb_state_e        state_q;
    mst_idx_t          last_gnt_q;
    mst_idx_t          gnt_q;
    logic              we_q;
    logic [1:0]        cnt_q;
    logic              bus_busy_q;
    logic [ADDR_W-1:0] port_id_q;
    logic [DATA_W-1:0] out_port_q;
    logic              write_strobe_q;
    logic              read_strobe_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    mst_idx_t          winner;

    bot_rr_pick u_pick (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_gnt_q),
        .winner   (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            last_gnt_q     <= MST_M1;
            gnt_q          <= MST_M0;
            we_q           <= 1'b0;
            cnt_q          <= 2'd0;
            bus_busy_q     <= 1'b0;
            port_id_q      <= '0;
            out_port_q     <= '0;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            m0_ack_q       <= 1'b0;
            m1_ack_q       <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
        end else begin
            // Strobes and acks are single-cycle; each state re-asserts only what it needs.
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            m0_ack_q       <= 1'b0;
            m1_ack_q       <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (bus_avail && (m0_req || m1_req)) begin
                        gnt_q      <= winner;
                        last_gnt_q <= winner;
                        we_q       <= (winner == MST_M1) ? m1_we    : m0_we;
                        port_id_q  <= (winner == MST_M1) ? m1_addr  : m0_addr;
                        out_port_q <= (winner == MST_M1) ? m1_wdata : m0_wdata;
                        bus_busy_q <= 1'b1;
                        state_q    <= StAddr;
                    end
                end

                StAddr: begin
                    if (we_q) begin
                        write_strobe_q <= 1'b1;
                        state_q        <= StStrb;
                    end else begin
                        cnt_q         <= RD_CNT_INIT;
                        read_strobe_q <= (RD_CNT_INIT == 2'd1);
                        state_q       <= StRwait;
                    end
                end

                StStrb: begin
                    m0_ack_q <= (gnt_q == MST_M0);
                    m1_ack_q <= (gnt_q == MST_M1);
                    state_q  <= StDone;
                end

                StRwait: begin
                    if (cnt_q == 2'd1) begin
                        if (gnt_q == MST_M0) begin
                            m0_rdata_q <= in_port;
                        end else begin
                            m1_rdata_q <= in_port;
                        end
                        m0_ack_q <= (gnt_q == MST_M0);
                        m1_ack_q <= (gnt_q == MST_M1);
                        state_q  <= StDone;
                    end else begin
                        // Strobe is registered, so raise it one count early to land in
                        // the last wait cycle.
                        read_strobe_q <= (cnt_q == 2'd2);
                        cnt_q         <= cnt_q - 2'd1;
                    end
                end

                StDone: begin
                    bus_busy_q <= 1'b0;
                    state_q    <= StIdle;
                end

                default: begin
                    bus_busy_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus_busy     = bus_busy_q;
    assign port_id      = port_id_q;
    assign out_port     = out_port_q;
    assign write_strobe = write_strobe_q;
    assign read_strobe  = read_strobe_q;
    assign m0_ack       = m0_ack_q;
    assign m1_ack       = m1_ack_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_bot_port_arbiter.sv
// Directed bench for bot_port_arbiter: a table of single transactions plus hand-written
// sequences for alternation, bus_avail stalls, mid-write reset and a 3-cycle read latency.
module tb_bot_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bus_avail = 1'b0;
    logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

    // RD_LAT = 1 instance
    logic       bus_busy, m0_ack, m1_ack, write_strobe, read_strobe;
    logic [7:0] m0_rdata, m1_rdata, port_id, out_port;
    logic [7:0] in_port = '0;

    // RD_LAT = 3 instance
    logic       bus_busy3, m0_ack3, m1_ack3, write_strobe3, read_strobe3;
    logic [7:0] m0_rdata3, m1_rdata3, port_id3, out_port3;
    logic [7:0] in_port3 = '0;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    bot_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus_avail(bus_avail), .bus_busy(bus_busy),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .in_port(in_port)
    );

    bot_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus_avail(bus_avail), .bus_busy(bus_busy3),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack3), .m0_rdata(m0_rdata3),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack3), .m1_rdata(m1_rdata3),
        .port_id(port_id3), .out_port(out_port3), .write_strobe(write_strobe3),
        .read_strobe(read_strobe3), .in_port(in_port3)
    );

    // Bot interface model: registered in_port looked up from port_id
    function automatic logic [7:0] slave_data(input logic [7:0] a);
        case (a)
            8'h0A:   return 8'h37;
            8'h0D:   return 8'hC4;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) begin
        in_port  <= slave_data(port_id);
        in_port3 <= slave_data(port_id3);
    end

    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       gnt;
        logic       we;
        logic [7:0] addr, wdata, rdata;
    } vec_t;

    vec_t vt [6];

    function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, d0,
                                input logic r1, w1, input logic [7:0] a1, d1,
                                input logic g, ew, input logic [7:0] ea, ed, er);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.gnt = g; v.we = ew; v.addr = ea; v.wdata = ed; v.rdata = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string s;
        s = $sformatf("v%0d", idx);
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        bus_avail = 1'b1;
        step();
        chk({s, "_c1_port_id"}, port_id, v.addr);
        chk({s, "_c1_busy"}, bus_busy, 1);
        chk({s, "_c1_strobes"}, {write_strobe, read_strobe}, 0);
        step();
        chk({s, "_c2_wstrb"}, write_strobe, v.we);
        chk({s, "_c2_rstrb"}, read_strobe, !v.we);
        if (v.we) chk({s, "_c2_out_port"}, out_port, v.wdata);
        step();
        if (!v.we) exp_rd[v.gnt] = v.rdata;
        chk({s, "_c3_m0_ack"}, m0_ack, v.gnt == 1'b0);
        chk({s, "_c3_m1_ack"}, m1_ack, v.gnt == 1'b1);
        chk({s, "_c3_m0_rdata"}, m0_rdata, exp_rd[0]);
        chk({s, "_c3_m1_rdata"}, m1_rdata, exp_rd[1]);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        chk({s, "_c4_idle"}, {bus_busy, m0_ack, m1_ack, write_strobe, read_strobe}, 0);
        chk({s, "_c4_port_id_held"}, port_id, v.addr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
    endtask

    initial begin
        logic       exp_g [4];
        int         errs;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;

        vt[0] = mk(1, 1, 8'h09, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 1, 8'h09, 8'h5A, 8'h00);
        vt[1] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h0A, 8'h00, 1, 0, 8'h0A, 8'h00, 8'h37);
        vt[2] = mk(1, 1, 8'h02, 8'h11, 1, 1, 8'h0B, 8'h22, 0, 1, 8'h02, 8'h11, 8'h00);
        vt[4] = mk(1, 0, 8'h0D, 8'h00, 1, 0, 8'h0A, 8'h00, 0, 0, 8'h0D, 8'h00, 8'hC4);
`ifdef BOT_ARB_FIXED_PRIO_EN
        vt[3] = mk(1, 0, 8'h0C, 8'h00, 1, 1, 8'h02, 8'h33, 0, 0, 8'h0C, 8'h00, 8'hA9);
        vt[5] = mk(1, 1, 8'h02, 8'h44, 1, 0, 8'h0E, 8'h00, 0, 1, 8'h02, 8'h44, 8'h00);
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        vt[3] = mk(1, 0, 8'h0C, 8'h00, 1, 1, 8'h02, 8'h33, 1, 1, 8'h02, 8'h33, 8'h00);
        vt[5] = mk(1, 1, 8'h02, 8'h44, 1, 0, 8'h0E, 8'h00, 1, 0, 8'h0E, 8'h00, 8'hAB);
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

        // Reset state
        step();
        step();
        chk("rst_busy", bus_busy, 0);
        chk("rst_port_id", port_id, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_strobes", {write_strobe, read_strobe}, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // Reset during the strobe cycle of an m0 write; held req reissues afterwards
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h09; m0_wdata = 8'h77;
        m1_req = 1'b0; bus_avail = 1'b1;
        step();
        step();
        chk("mid_rst_pre_wstrb", write_strobe, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wstrb", write_strobe, 0);
        chk("mid_rst_busy", bus_busy, 0);
        chk("mid_rst_ack", m0_ack, 0);
        chk("mid_rst_rdata", {m0_rdata, m1_rdata}, 0);
        step();
        chk("mid_rst_ack_hold", {m0_ack, m1_ack}, 0);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        step();
        chk("reissue_port_id", port_id, 8'h09);
        step();
        chk("reissue_wstrb", write_strobe, 1);
        chk("reissue_out_port", out_port, 8'h77);
        step();
        chk("reissue_ack", m0_ack, 1);
        m0_req = 1'b0;
        step();

        // Both masters hold write requests across four transactions
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h02; m0_wdata = 8'h10;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h0B; m1_wdata = 8'h20;
        bus_avail = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            chk($sformatf("alt%0d_port_id", t), port_id, exp_g[t] ? 8'h0B : 8'h02);
            step();
            step();
            chk($sformatf("alt%0d_acks", t), {m1_ack, m0_ack}, exp_g[t] ? 2'b10 : 2'b01);
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();

        // bus_avail low stalls a pending request
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h02; m0_wdata = 8'h5C;
        bus_avail = 1'b0;
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if ({bus_busy, write_strobe, read_strobe, m0_ack, m1_ack} !== 5'b0) errs++;
        end
        chk("avail_low_quiet_cycles", errs, 0);
        bus_avail = 1'b1;
        step();
        chk("avail_start_busy", bus_busy, 1);
        chk("avail_start_port_id", port_id, 8'h02);
        step();
        chk("avail_wstrb", write_strobe, 1);
        step();
        chk("avail_ack", m0_ack, 1);
        m0_req = 1'b0;
        step();

        // RD_LAT = 3 read
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h0D;
        m1_req = 1'b0; bus_avail = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("lat3_c%0d_port_id", c), port_id3, 8'h0D);
            chk($sformatf("lat3_c%0d_rstrb", c), read_strobe3, c == 4);
            chk($sformatf("lat3_c%0d_ack", c), m0_ack3, 0);
        end
        step();
        chk("lat3_c5_ack", m0_ack3, 1);
        chk("lat3_c5_rdata", m0_rdata3, 8'hC4);
        chk("lat3_c5_m1_rdata", m1_rdata3, 8'h00);
        chk("lat3_c5_rstrb", read_strobe3, 0);
        m0_req = 1'b0;
        step();
        chk("lat3_c6_idle", {bus_busy3, m0_ack3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
